bip_datapath: RTL and testbench

Datapath and program-sequencing stage of the accumulator CPU. It sits directly downstream of the instruction decoder: it consumes the decoder's control word (WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam) and the current instruction word, and it holds the program counter, accumulator, halt state and cycle counter. It drives program-memory and data-memory addressing, and reports results to the UART reporting logic.

---
 rtl/bip_datapath_if.sv | 38 +++
 rtl/bip_datapath.sv | 90 +++++++++
 tb/tb_bip_datapath.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bip_datapath_if.sv
// Datapath bus: decoder controls, instruction word, data-memory port
// and the architectural state reported back to the rest of the CPU.
interface bip_datapath_if #(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int OPC_W  = 5
);
    logic [OPC_W+PC_W-1:0] instr;
    logic                  WrPC;
    logic [1:0]            SelA;
    logic                  SelB;
    logic                  WrAcc;
    logic                  Op;
    logic                  WrRam;
    logic                  RdRam;
    logic [DATA_W-1:0]     dm_rd_data;
    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       dm_addr;
    logic [DATA_W-1:0]     dm_wr_data;
    logic                  dm_we;
    logic                  dm_re;
    logic [DATA_W-1:0]     acc;
    logic [15:0]           cycles;
    logic                  halted;
    logic                  halt_pulse;

    // Decoder / memory / reporting side
    modport master (
        output instr, WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, dm_rd_data,
        input  pc, dm_addr, dm_wr_data, dm_we, dm_re, acc, cycles, halted, halt_pulse
    );

    // Datapath side
    modport slave (
        input  instr, WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, dm_rd_data,
        output pc, dm_addr, dm_wr_data, dm_we, dm_re, acc, cycles, halted, halt_pulse
    );
endinterface

// File: rtl/bip_datapath.sv
// Accumulator CPU datapath: PC, accumulator, ALU, halt FSM and cycle counter.
module bip_datapath #(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int OPC_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    bip_datapath_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t            state, stateNext;
    logic [PC_W-1:0]   pcReg;
    logic [DATA_W-1:0] accReg, accNext, imm, opB, aluRes;
    logic [15:0]       cycleCnt;
    logic              haltPulse;
    logic              active, isHlt;
    logic [OPC_W-1:0]  opcode;

    assign opcode = bus.instr[OPC_W+PC_W-1:PC_W];
    assign imm    = {{(DATA_W-PC_W){bus.instr[PC_W-1]}}, bus.instr[PC_W-1:0]};
    assign active = enable && (state == RUN);
    // Opcode 0 with no PC advance is HLT; a nonzero opcode with WrPC=0 just stalls.
    assign isHlt  = active && (opcode == '0) && !bus.WrPC;

    assign opB    = bus.SelB ? imm : bus.dm_rd_data;
    assign aluRes = bus.Op ? (accReg + opB) : (accReg - opB);

    // Accumulator source mux; SelA=3 is reserved and holds
    always_comb begin
        accNext = accReg;
        case (bus.SelA)
            2'd0:    accNext = bus.dm_rd_data;
            2'd1:    accNext = imm;
            2'd2:    accNext = aluRes;
            default: accNext = accReg;
        endcase
    end

    // Halt FSM next state: HALT is only left through reset
    always_comb begin
        stateNext = state;
        if (isHlt)
            stateNext = HALT;
    end

    // Halt FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= stateNext;
    end

    // Halt entry pulse, cleared on any cycle that is not the HLT edge
    always_ff @(posedge clk) begin
        if (reset)
            haltPulse <= 1'b0;
        else
            haltPulse <= isHlt;
    end

    // Program counter, accumulator and saturating cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pcReg    <= '0;
            accReg   <= '0;
            cycleCnt <= '0;
        end else if (active) begin
            if (bus.WrPC)
                pcReg <= pcReg + 1'b1;
            if (bus.WrAcc && !isHlt)
                accReg <= accNext;
            if (cycleCnt != 16'hFFFF)
                cycleCnt <= cycleCnt + 16'd1;
        end
    end

    assign bus.pc         = pcReg;
    assign bus.acc        = accReg;
    assign bus.cycles     = cycleCnt;
    assign bus.halted     = (state == HALT);
    assign bus.halt_pulse = haltPulse;
    assign bus.dm_addr    = bus.instr[PC_W-1:0];
    assign bus.dm_wr_data = accReg;
    assign bus.dm_we      = bus.WrRam && active;
    assign bus.dm_re      = bus.RdRam && active;
endmodule

// File: tb/tb_bip_datapath.sv
// Directed bench for bip_datapath with a behavioural data RAM.
module tb_bip_datapath;
    localparam int PC_W = 11, DATA_W = 16, OPC_W = 5;
    localparam logic [4:0] HLT = 5'd0, LDI = 5'd1, ADDI = 5'd2, STO = 5'd3,
                           LD = 5'd4, SUB = 5'd5, ADD = 5'd6, BAD = 5'd31;

    logic clk = 1'b0;
    logic reset, enable;
    int   pass = 0, total = 0;
    logic [DATA_W-1:0] ram [0:(1<<PC_W)-1];

    bip_datapath_if #(.PC_W(PC_W), .DATA_W(DATA_W), .OPC_W(OPC_W)) bus ();

    bip_datapath #(.PC_W(PC_W), .DATA_W(DATA_W), .OPC_W(OPC_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous write, asynchronous read
    always @(posedge clk) if (bus.dm_we) ram[bus.dm_addr] <= bus.dm_wr_data;
    assign bus.dm_rd_data = ram[bus.dm_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive the instruction word and the control word a decoder would produce
    task automatic issue(input logic [4:0] opc, input logic [10:0] opd);
        bus.instr = {opc, opd};
        bus.WrPC = 1'b0; bus.SelA = 2'd3; bus.SelB = 1'b0; bus.WrAcc = 1'b0;
        bus.Op = 1'b0; bus.WrRam = 1'b0; bus.RdRam = 1'b0;
        case (opc)
            LDI:  begin bus.WrPC = 1; bus.SelA = 2'd1; bus.WrAcc = 1; end
            ADDI: begin bus.WrPC = 1; bus.SelA = 2'd2; bus.SelB = 1; bus.Op = 1; bus.WrAcc = 1; end
            STO:  begin bus.WrPC = 1; bus.WrRam = 1; end
            LD:   begin bus.WrPC = 1; bus.SelA = 2'd0; bus.WrAcc = 1; bus.RdRam = 1; end
            SUB:  begin bus.WrPC = 1; bus.SelA = 2'd2; bus.Op = 0; bus.WrAcc = 1; bus.RdRam = 1; end
            ADD:  begin bus.WrPC = 1; bus.SelA = 2'd2; bus.Op = 1; bus.WrAcc = 1; bus.RdRam = 1; end
            default: ;
        endcase
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [4:0] opc, input logic [10:0] opd);
        issue(opc, opd);
        tick();
    endtask

    task automatic chkReset(input string tag);
        chk({tag, ".pc"}, 32'(bus.pc), 0);
        chk({tag, ".acc"}, 32'(bus.acc), 0);
        chk({tag, ".cycles"}, 32'(bus.cycles), 0);
        chk({tag, ".halted"}, 32'(bus.halted), 0);
        chk({tag, ".pulse"}, 32'(bus.halt_pulse), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) ram[i] = '0;
        reset = 1'b1; enable = 1'b1;
        issue(LDI, 11'd0);
        tick(); tick();
        chkReset("rst");
        reset = 1'b0;

        // Strobes gated by enable
        enable = 1'b0;
        issue(STO, 11'd1);
        chk("we_disabled", 32'(bus.dm_we), 0);
        issue(LD, 11'd1);
        chk("re_disabled", 32'(bus.dm_re), 0);
        enable = 1'b1;

        // LDI 5, ADDI -3
        run(LDI, 11'd5);
        chk("ldi.acc", 32'(bus.acc), 5);
        chk("ldi.pc", 32'(bus.pc), 1);
        run(ADDI, 11'h7FD);
        chk("addi.acc", 32'(bus.acc), 2);
        chk("addi.pc", 32'(bus.pc), 2);
        chk("addi.cycles", 32'(bus.cycles), 2);

        // STO 7 then LD 7
        issue(STO, 11'd7);
        chk("sto.we", 32'(bus.dm_we), 1);
        chk("sto.addr", 32'(bus.dm_addr), 7);
        chk("sto.data", 32'(bus.dm_wr_data), 2);
        tick();
        issue(LD, 11'd7);
        chk("ld.we", 32'(bus.dm_we), 0);
        chk("ld.re", 32'(bus.dm_re), 1);
        chk("ld.rdata", 32'(bus.dm_rd_data), 2);
        tick();
        chk("ld.acc", 32'(bus.acc), 2);
        chk("ld.pc", 32'(bus.pc), 4);

        // HLT at pc=4; enable drops during the pulse cycle
        run(HLT, 11'd0);
        chk("hlt.halted", 32'(bus.halted), 1);
        chk("hlt.pulse", 32'(bus.halt_pulse), 1);
        chk("hlt.pc", 32'(bus.pc), 4);
        chk("hlt.cycles", 32'(bus.cycles), 5);
        chk("hlt.acc", 32'(bus.acc), 2);
        enable = 1'b0;
        run(STO, 11'd9);
        chk("hlt.pulse_once", 32'(bus.halt_pulse), 0);
        enable = 1'b1;
        issue(STO, 11'd9);
        chk("halted.we", 32'(bus.dm_we), 0);
        tick();
        run(LDI, 11'd33);
        chk("halted.pc", 32'(bus.pc), 4);
        chk("halted.acc", 32'(bus.acc), 2);
        chk("halted.cycles", 32'(bus.cycles), 5);
        chk("halted.sticky", 32'(bus.halted), 1);
        chk("halted.pulse", 32'(bus.halt_pulse), 0);

        // Reset while halted, then LDI 9
        reset = 1'b1;
        run(LDI, 11'd9);
        chkReset("rst_halt");
        reset = 1'b0;
        run(LDI, 11'd9);
        chk("post_rst.acc", 32'(bus.acc), 9);
        chk("post_rst.pc", 32'(bus.pc), 1);

        // RAM[3]=1, acc=0, SUB 3 -> 0xFFFF, ADD 3 -> 0
        run(LDI, 11'd1);
        run(STO, 11'd3);
        run(LDI, 11'd0);
        run(SUB, 11'd3);
        chk("sub.wrap", 32'(bus.acc), 32'hFFFF);
        run(ADD, 11'd3);
        chk("add.wrap", 32'(bus.acc), 0);
        chk("add.cycles", 32'(bus.cycles), 6);

        // Unknown opcode stalls at the same pc without halting
        run(BAD, 11'd0);
        chk("bad.pc", 32'(bus.pc), 6);
        chk("bad.halted", 32'(bus.halted), 0);
        chk("bad.pulse", 32'(bus.halt_pulse), 0);
        chk("bad.cycles", 32'(bus.cycles), 7);

        // Enable gap of three cycles changes nothing
        enable = 1'b0;
        run(ADDI, 11'd1);
        run(ADDI, 11'd1);
        run(ADDI, 11'd1);
        chk("gap.pc", 32'(bus.pc), 6);
        chk("gap.acc", 32'(bus.acc), 0);
        chk("gap.cycles", 32'(bus.cycles), 7);
        enable = 1'b1;
        run(ADDI, 11'd1);
        chk("gap.resume", 32'(bus.acc), 1);

        // Mid-run reset, then PC wrap
        reset = 1'b1;
        run(ADDI, 11'd0);
        chkReset("rst_run");
        reset = 1'b0;
        issue(ADDI, 11'd0);
        for (int i = 0; i < 2047; i++) tick();
        chk("wrap.pc_max", 32'(bus.pc), 2047);
        tick();
        chk("wrap.pc_zero", 32'(bus.pc), 0);
        chk("wrap.cycles", 32'(bus.cycles), 2048);

        // Cycle counter saturation
        for (int i = 0; i < 65535 - 2048; i++) tick();
        chk("sat.reach", 32'(bus.cycles), 32'hFFFF);
        tick();
        chk("sat.hold", 32'(bus.cycles), 32'hFFFF);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
